div_unit_mq: RTL and testbench

Parametrised successor to the single-slot divider unit: a RISC-V M-extension divide/remainder execution unit with configurable datapath width, a configurable-depth input queue, and an internal early-terminating radix-2 core. It sits between issue and writeback like the other execution units. It accepts DIV/DIVU/REM/REMU, queues up to QUEUE_DEPTH requests, computes one at a time, and holds each result on the writeback port until acknowledged. It optionally detects a repeated operand pair (e.g. DIV followed by REM on the same registers) and returns the result without recomputation.

---
 rtl/cva5_types.sv | 13 +
 rtl/div_iter_core.sv | 48 ++++
 rtl/div_unit_mq.sv | 211 +++++++++++++++++++++
 tb/tb_div_unit_mq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cva5_types.sv
// rtl/cva5_types.sv - shared op encodings and FSM state type for the divider unit
package cva5_types;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_fsm_t;
endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - early-terminating radix-2 restoring divider on unsigned magnitudes
module div_iter_core #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIV_WIDTH-1:0]       dividend,
  input  logic [DIV_WIDTH-1:0]       divisor,
  input  logic [$clog2(DIV_WIDTH):0] dividend_clz,
  input  logic [$clog2(DIV_WIDTH):0] divisor_clz,
  output logic [DIV_WIDTH-1:0]       quotient,
  output logic [DIV_WIDTH-1:0]       remainder,
  output logic                       done
);
  localparam int CLZ_W = $clog2(DIV_WIDTH) + 1;

  logic [DIV_WIDTH-1:0] quo_r, rem_r, div_r;
  logic [CLZ_W-1:0]     count, shift;
  logic [DIV_WIDTH:0]   diff;

  // Only called with divisor_clz >= dividend_clz, so the aligned divisor never overflows.
  assign shift = divisor_clz - dividend_clz;
  assign diff  = {1'b0, rem_r} - {1'b0, div_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r <= '0;
      rem_r <= '0;
      div_r <= '0;
      count <= '0;
    end else if (start) begin
      quo_r <= '0;
      rem_r <= dividend;
      div_r <= divisor << shift;
      count <= shift + CLZ_W'(1);
    end else if (count != '0) begin
      quo_r <= {quo_r[DIV_WIDTH-2:0], ~diff[DIV_WIDTH]};
      if (!diff[DIV_WIDTH]) rem_r <= diff[DIV_WIDTH-1:0];
      div_r <= div_r >> 1;
      count <= count - 1'b1;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign done      = (count == CLZ_W'(1));
endmodule

// File: rtl/div_unit_mq.sv
// rtl/div_unit_mq.sv - queued DIV/DIVU/REM/REMU unit; DIV_UNIT_REUSE_EN enables the operand-reuse store
module div_unit_mq
  import cva5_types::*;
#(
  parameter int DIV_WIDTH   = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter int ID_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_new_request,
  output logic                 issue_ready,
  input  logic [ID_WIDTH-1:0]  issue_id,
  input  logic [1:0]           op,
  input  logic [DIV_WIDTH-1:0] rs1,
  input  logic [DIV_WIDTH-1:0] rs2,
  output logic                 wb_done,
  input  logic                 wb_ack,
  output logic [DIV_WIDTH-1:0] wb_rd,
  output logic [ID_WIDTH-1:0]  wb_id
);
  localparam int CLZ_W = $clog2(DIV_WIDTH) + 1;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [CLZ_W-1:0]     dividend_clz;
    logic [CLZ_W-1:0]     divisor_clz;
    logic                 divisor_is_zero;
    logic                 negate_result;
    logic                 remainder_op;
    logic [ID_WIDTH-1:0]  id;
`ifdef DIV_UNIT_REUSE_EN
    logic [DIV_WIDTH-1:0] rs1;
    logic [DIV_WIDTH-1:0] rs2;
    logic                 op_unsigned;
`endif
  } entry_t;

  function automatic logic [CLZ_W-1:0] clz(input logic [DIV_WIDTH-1:0] v);
    logic [CLZ_W-1:0] result;
    result = CLZ_W'(DIV_WIDTH);
    for (int i = 0; i < DIV_WIDTH; i++) if (v[i]) result = CLZ_W'(DIV_WIDTH - 1 - i);
    return result;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] negate_if(input logic [DIV_WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic                 is_signed, rs1_neg, rs2_neg, divisor_zero;
  logic [DIV_WIDTH-1:0] dividend_mag, divisor_mag;
  entry_t               new_entry, head;

  assign is_signed    = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign rs1_neg      = is_signed & rs1[DIV_WIDTH-1];
  assign rs2_neg      = is_signed & rs2[DIV_WIDTH-1];
  assign dividend_mag = negate_if(rs1, rs1_neg);
  assign divisor_mag  = negate_if(rs2, rs2_neg);
  assign divisor_zero = (rs2 == '0);

  always_comb begin
    new_entry                 = '0;
    new_entry.dividend        = dividend_mag;
    new_entry.divisor         = divisor_mag;
    new_entry.dividend_clz    = clz(dividend_mag);
    new_entry.divisor_clz     = clz(divisor_mag);
    new_entry.divisor_is_zero = divisor_zero;
    new_entry.remainder_op    = op[1];
    new_entry.negate_result   = op[1] ? rs1_neg : ((rs1_neg ^ rs2_neg) & ~divisor_zero);
    new_entry.id              = issue_id;
`ifdef DIV_UNIT_REUSE_EN
    new_entry.rs1             = rs1;
    new_entry.rs2             = rs2;
    new_entry.op_unsigned     = op[0];
`endif
  end

  entry_t           queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, q_valid, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == CNT_W'(QUEUE_DEPTH));
  assign q_valid     = (count != '0);
  assign issue_ready = ~full;
  assign push        = issue_new_request & ~full;
  assign head        = queue_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= new_entry;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(issue_new_request && full));

  logic                 trivial, reuse_hit, head_fast, core_start, core_done;
  logic [DIV_WIDTH-1:0] core_quo, core_rem;

  assign trivial    = head.divisor_clz < head.dividend_clz;
  assign head_fast  = head.divisor_is_zero | trivial | reuse_hit;
  assign core_start = pop & ~head_fast;

`ifdef DIV_UNIT_REUSE_EN
  // The stored magnitudes are the core's own result registers, which only change on core_start.
  logic [DIV_WIDTH-1:0] last_rs1, last_rs2;
  logic                 last_unsigned, reuse_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rs1      <= '0;
      last_rs2      <= '0;
      last_unsigned <= 1'b0;
      reuse_valid   <= 1'b0;
    end else if (core_start) begin
      last_rs1      <= head.rs1;
      last_rs2      <= head.rs2;
      last_unsigned <= head.op_unsigned;
      reuse_valid   <= 1'b1;
    end
  end

  assign reuse_hit = reuse_valid && (head.rs1 == last_rs1) && (head.rs2 == last_rs2)
                     && (head.op_unsigned == last_unsigned);
`else
  assign reuse_hit = 1'b0;
`endif

  div_fsm_t state, next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      DIV_IDLE: pop = q_valid;
      DIV_BUSY: if (core_done) next_state = DIV_DONE;
      DIV_DONE: begin
        if (wb_ack) begin
          if (q_valid) pop = 1'b1;
          else next_state = DIV_IDLE;
        end
      end
      default: next_state = DIV_IDLE;
    endcase
    if (pop) next_state = head_fast ? DIV_DONE : DIV_BUSY;
  end

  div_iter_core #(.DIV_WIDTH(DIV_WIDTH)) core_i (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (core_start),
    .dividend     (head.dividend),
    .divisor      (head.divisor),
    .dividend_clz (head.dividend_clz),
    .divisor_clz  (head.divisor_clz),
    .quotient     (core_quo),
    .remainder    (core_rem),
    .done         (core_done)
  );

  logic [DIV_WIDTH-1:0] res_quo, res_rem, res_mag;
  logic                 res_from_core, res_neg, res_rem_op;
  logic [ID_WIDTH-1:0]  res_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_quo       <= '0;
      res_rem       <= '0;
      res_from_core <= 1'b0;
      res_neg       <= 1'b0;
      res_rem_op    <= 1'b0;
      res_id        <= '0;
    end else if (pop) begin
      res_quo       <= head.divisor_is_zero ? '1 : '0;
      res_rem       <= head.dividend;
      res_from_core <= ~head.divisor_is_zero & ~trivial;
      res_neg       <= head.negate_result;
      res_rem_op    <= head.remainder_op;
      res_id        <= head.id;
    end
  end

  assign res_mag = res_rem_op ? (res_from_core ? core_rem : res_rem)
                              : (res_from_core ? core_quo : res_quo);
  assign wb_rd   = negate_if(res_mag, res_neg);
  assign wb_id   = res_id;
  assign wb_done = (state == DIV_DONE);
endmodule

// File: tb/tb_div_unit_mq.sv
// tb/tb_div_unit_mq.sv - self-checking bench for div_unit_mq against an arithmetic reference model
module tb_div_unit_mq;
  import cva5_types::*;

`ifdef DIV_UNIT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_new_request;
  logic        issue_ready;
  logic [2:0]  issue_id;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        wb_done;
  logic        wb_ack;
  logic [31:0] wb_rd;
  logic [2:0]  wb_id;

  always #5 clk = ~clk;

  div_unit_mq #(.DIV_WIDTH(32), .QUEUE_DEPTH(2), .ID_WIDTH(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .issue_new_request (issue_new_request),
    .issue_ready       (issue_ready),
    .issue_id          (issue_id),
    .op                (op),
    .rs1               (rs1),
    .rs2               (rs2),
    .wb_done           (wb_done),
    .wb_ack            (wb_ack),
    .wb_rd             (wb_rd),
    .wb_id             (wb_id)
  );

  typedef struct {
    logic [2:0]  id;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          done_q[$];
  int          ack_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          issue_c = 0;
  bit          holding = 1'b0;
  logic [31:0] held_rd;
  logic [2:0]  held_id;
  int          first_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V M-extension semantics straight from the ISA rules.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      if (o[1]) return $signed(a) % $signed(b);
      return $signed(a) / $signed(b);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) holding = 1'b0;
    else if (wb_done) begin
      if (!holding) begin
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          holding    = 1'b1;
          held_rd    = wb_rd;
          held_id    = wb_id;
          first_seen = cyc;
        end
      end else begin
        check("rd_stable", wb_rd, held_rd);
        check("id_stable", 32'(wb_id), 32'(held_id));
      end
      if (holding && wb_ack) begin
        cur = exp_q.pop_front();
        check("wb_rd", wb_rd, cur.rd);
        check("wb_id", 32'(wb_id), 32'(cur.id));
        done_q.push_back(first_seen);
        ack_q.push_back(cyc);
        holding = 1'b0;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] i, input logic [31:0] lit);
    exp_t e;
    check("model_pin", model(o, a, b), lit);
    check("issue_ready", 32'(issue_ready), 32'd1);
    e.id = i;
    e.rd = model(o, a, b);
    exp_q.push_back(e);
    issue_c           = cyc;
    issue_new_request = 1'b1;
    op                = o;
    rs1               = a;
    rs2               = b;
    issue_id          = i;
    @(posedge clk); #1;
    issue_new_request = 1'b0;
  endtask

  task automatic drain(input string name, input int lat);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout with %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      check(name, 32'(done_q[$] - issue_c), 32'(lat));
    end
    @(posedge clk); #1;
  endtask

  task automatic ack_one();
    int k = 0;
    @(negedge clk);
    while (!wb_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!wb_done) begin
      checks++;
      failures++;
      $display("FAIL ack_wait: wb_done=0 after 100 cycles, required 1");
    end
    @(posedge clk); #1 wb_ack = 1'b1;
    @(posedge clk); #1 wb_ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 1'b0; issue_new_request = 1'b0; wb_ack = 1'b0;
    op = 2'b00; rs1 = '0; rs2 = '0; issue_id = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_wb_done", 32'(wb_done), 32'd0);
    check("rst_wb_rd", wb_rd, 32'd0);
    check("rst_wb_id", 32'(wb_id), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    wb_ack = 1'b1;
    issue(DIV_OP_DIV,  32'd100, 32'd7, 3'd1, 32'd14);        drain("lat_div_100_7", 7);
    issue(DIV_OP_REM,  32'd100, 32'd7, 3'd2, 32'd2);         drain("lat_rem_100_7", REUSE ? 2 : 7);
    issue(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 3'd3, 32'hFFFF_FFFD); drain("lat_div_m7_2", 4);
    issue(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 3'd4, 32'hFFFF_FFFF); drain("lat_rem_m7_2", REUSE ? 2 : 4);
    issue(DIV_OP_DIVU, 32'hFFFF_FFF9, 32'd2, 3'd5, 32'h7FFF_FFFC); drain("lat_divu_big", 33);
    issue(DIV_OP_DIV,  32'd5, 32'd0, 3'd6, 32'hFFFF_FFFF);   drain("lat_div_by_zero", 2);
    issue(DIV_OP_REM,  32'hFFFF_FFFB, 32'd0, 3'd7, 32'hFFFF_FFFB); drain("lat_rem_by_zero", 2);
    issue(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 3'd0, 32'h8000_0000); drain("lat_overflow_div", 34);
    issue(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 32'd0); drain("lat_overflow_rem", REUSE ? 2 : 34);
    issue(DIV_OP_DIVU, 32'd3, 32'd1000, 3'd2, 32'd0);        drain("lat_trivial_divu", 2);
    issue(DIV_OP_REMU, 32'd3, 32'd1000, 3'd3, 32'd3);        drain("lat_trivial_remu", 2);

    wb_ack = 1'b0;
    done_q.delete();
    ack_q.delete();
    issue(DIV_OP_DIV,  32'd1000, 32'd3, 3'd1, 32'd333);
    issue(DIV_OP_REMU, 32'd77, 32'd5, 3'd2, 32'd2);
    issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 3'd3, 32'hFFFF_FFFF);
    check("ready_when_full", 32'(issue_ready), 32'd0);
    ack_one();
    check("ready_after_ack", 32'(issue_ready), 32'd1);
    issue(DIV_OP_DIV,  32'hFFFF_FF9C, 32'd9, 3'd4, 32'hFFFF_FFF5);
    ack_one();
    ack_one();
    ack_one();
    check("b2b_ack_to_done_n5", 32'(done_q[1] - ack_q[0]), 32'd6);
    check("b2b_ack_to_done_n32", 32'(done_q[2] - ack_q[1]), 32'd33);
    check("queue_all_released", 32'(exp_q.size()), 32'd0);

    issue(DIV_OP_DIVU, 32'hFFFF_FFF0, 32'd3, 3'd5, 32'h5555_5550);
    issue(DIV_OP_REMU, 32'd1234, 32'd10, 3'd6, 32'd4);
    issue(DIV_OP_DIV,  32'd99, 32'd4, 3'd7, 32'd24);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_wb_done", 32'(wb_done), 32'd0);
    check("midrst_issue_ready", 32'(issue_ready), 32'd1);
    check("midrst_wb_rd", wb_rd, 32'd0);
    check("midrst_wb_id", 32'(wb_id), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (wb_done) seen++;
    end
    check("no_result_after_reset", 32'(seen), 32'd0);

    @(posedge clk); #1;
    wb_ack = 1'b1;
    issue(DIV_OP_DIV, 32'd100, 32'd7, 3'd1, 32'd14);
    drain("lat_after_reset", 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
